// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between ALU and
//               out-of-order cache writebacks, tracks in-flight load
//               destinations and raises issue-stage STALL on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_ADDR,
    input  logic [31:0] ALU_DATA,
    output logic        ALU_READY,
    input  logic        LD_ISSUE,
    input  logic [4:0]  LD_ADDR,
    output logic        LD_READY,
    input  logic        MEM_VALID,
    input  logic [31:0] MEM_DATA,
    input  logic [4:0]  RS1_ADDR,
    input  logic [4:0]  RS2_ADDR,
    input  logic [4:0]  RD_ADDR,
    output logic        STALL,
    output logic        ERR,
    output logic        WRITE,
    output logic [4:0]  INADDRESS,
    output logic [31:0] IN
);

    localparam int                 c_PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(LQ_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]          r_lq [LQ_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_hold_v;
    logic [4:0]          r_hold_addr;
    logic [31:0]         r_hold_data;
    logic                r_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [4:0]          w_head;
    logic                w_sel_mem;
    logic                w_sel_hold;
    logic                w_sel_alu;
    logic                w_capture;
    logic [4:0]          w_sel_addr;
    logic [31:0]         w_sel_data;
    logic                w_write;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign LD_READY  = !w_full;
    assign ALU_READY = !r_hold_v;
    assign w_push    = LD_ISSUE && !w_full;
    assign w_pop     = MEM_VALID && !w_empty;
    assign w_head    = r_lq[r_rd_ptr];

    // Fixed priority MEM > HOLD > ALU; the cache cannot be back-pressured.
    assign w_sel_mem  = w_pop;
    assign w_sel_hold = !w_pop && r_hold_v;
    assign w_sel_alu  = !w_pop && !r_hold_v && ALU_VALID;
    assign w_capture  = w_pop && ALU_VALID && !r_hold_v;

    always_comb begin
        w_sel_addr = ALU_ADDR;
        w_sel_data = ALU_DATA;
        if (w_sel_mem) begin
            w_sel_addr = w_head;
            w_sel_data = MEM_DATA;
        end else if (w_sel_hold) begin
            w_sel_addr = r_hold_addr;
            w_sel_data = r_hold_data;
        end
    end

    // x0 is hard-wired zero: any write aimed at it is suppressed here.
    assign w_write   = (w_sel_mem || w_sel_hold || w_sel_alu) && (w_sel_addr != 5'd0) && !RESET;
    assign WRITE     = w_write;
    assign INADDRESS = w_write ? w_sel_addr : 5'd0;
    assign IN        = w_write ? w_sel_data : 32'd0;
    assign ERR       = r_err;

    // ------------------------------------------------------------------
    // Load destination FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < LQ_DEPTH; k++) begin
                r_lq[k] <= 5'd0;
            end
        end else begin
            if (w_push) begin
                r_lq[r_wr_ptr] <= LD_ADDR;
                r_wr_ptr       <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold register for an ALU write displaced by a cache return
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hold_v    <= 1'b0;
            r_hold_addr <= 5'd0;
            r_hold_data <= 32'd0;
        end else if (w_capture) begin
            r_hold_v    <= 1'b1;
            r_hold_addr <= ALU_ADDR;
            r_hold_data <= ALU_DATA;
        end else if (w_sel_hold) begin
            r_hold_v    <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else if (MEM_VALID && w_empty) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection against uncommitted destinations
    // ------------------------------------------------------------------
    logic [LQ_DEPTH-1:0] w_ent_valid;
    logic [LQ_DEPTH-1:0] w_hit_rs1;
    logic [LQ_DEPTH-1:0] w_hit_rs2;
    logic [LQ_DEPTH-1:0] w_hit_rd;

    for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_entry
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(i);
        logic [c_PTR_W-1:0] w_offs;
        // An entry is live when its distance from the read pointer is below count.
        assign w_offs         = c_IDX - r_rd_ptr;
        assign w_ent_valid[i] = ({1'b0, w_offs} < r_count);
        assign w_hit_rs1[i]   = w_ent_valid[i] && (RS1_ADDR == r_lq[i]);
        assign w_hit_rs2[i]   = w_ent_valid[i] && (RS2_ADDR == r_lq[i]);
        assign w_hit_rd[i]    = w_ent_valid[i] && (RD_ADDR  == r_lq[i]);
    end

    logic w_rs1_nz;
    logic w_rs2_nz;
    logic w_rd_nz;
    logic w_raw_load;
    logic w_raw_hold;
    logic w_waw_load;

    assign w_rs1_nz   = (RS1_ADDR != 5'd0);
    assign w_rs2_nz   = (RS2_ADDR != 5'd0);
    assign w_rd_nz    = (RD_ADDR  != 5'd0);
    assign w_raw_load = (w_rs1_nz && |w_hit_rs1) || (w_rs2_nz && |w_hit_rs2);
    assign w_raw_hold = r_hold_v && ((w_rs1_nz && (RS1_ADDR == r_hold_addr)) ||
                                     (w_rs2_nz && (RS2_ADDR == r_hold_addr)));
    assign w_waw_load = w_rd_nz && |w_hit_rd;
    assign STALL      = w_raw_load || w_raw_hold || w_waw_load || w_full;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ALU_VALID;
    logic [4:0]  ALU_ADDR;
    logic [31:0] ALU_DATA;
    logic        ALU_READY;
    logic        LD_ISSUE;
    logic [4:0]  LD_ADDR;
    logic        LD_READY;
    logic        MEM_VALID;
    logic [31:0] MEM_DATA;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic [4:0]  RD_ADDR;
    logic        STALL;
    logic        ERR;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.LQ_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .LD_ISSUE(LD_ISSUE), .LD_ADDR(LD_ADDR), .LD_READY(LD_READY),
        .MEM_VALID(MEM_VALID), .MEM_DATA(MEM_DATA),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
        .STALL(STALL), .ERR(ERR),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
    );

    always #5 CLK = ~CLK;

    // Register file model written on the same posedge as the DUT outputs.
    logic [31:0] rf [32];
    always @(posedge CLK) begin
        if (WRITE) rf[INADDRESS] <= IN;
    end

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic idle();
        ALU_VALID = 0; ALU_ADDR = 0; ALU_DATA = 0;
        LD_ISSUE = 0; LD_ADDR = 0; MEM_VALID = 0; MEM_DATA = 0;
        RS1_ADDR = 0; RS2_ADDR = 0; RD_ADDR = 0;
    endtask

    task automatic test_reset();
        RESET = 1; idle();
        ALU_VALID = 1; ALU_ADDR = 5; ALU_DATA = 32'h1111;
        cyc(); cyc(); #1;
        checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL rst_write got=%0h exp=0", WRITE); end
        checks++; if (INADDRESS !== 5'd0 || IN !== 32'd0) begin failures++; $display("FAIL rst_port got=%0h/%0h exp=0/0", INADDRESS, IN); end
        checks++; if (LD_READY !== 1'b1 || ALU_READY !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b%0b exp=11", LD_READY, ALU_READY); end
        checks++; if (STALL !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL rst_stall_err got=%0b%0b exp=00", STALL, ERR); end
        cyc(); RESET = 0; idle();
    endtask

    task automatic test_alu_write();
        cyc(); ALU_VALID = 1; ALU_ADDR = 5; ALU_DATA = 32'hDEADBEEF; #1;
        checks++; if (WRITE !== 1'b1 || INADDRESS !== 5'd5 || IN !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef", WRITE, INADDRESS, IN); end
        cyc(); idle(); #1;
        checks++; if (rf[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_rf5 got=%h exp=deadbeef", rf[5]); end
        checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL alu_idle_write got=%0b exp=0", WRITE); end
    endtask

    task automatic test_load_raw();
        cyc(); LD_ISSUE = 1; LD_ADDR = 7;
        for (int c = 0; c < 2; c++) begin
            cyc(); idle(); RS1_ADDR = 7; #1;
            checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL raw_wait%0d got=%0b exp=1", c, STALL); end
        end
        cyc(); MEM_VALID = 1; MEM_DATA = 32'h12345678; #1;
        checks++; if (WRITE !== 1'b1 || INADDRESS !== 5'd7 || IN !== 32'h12345678) begin failures++; $display("FAIL raw_ret got=%0b/%0d/%h exp=1/7/12345678", WRITE, INADDRESS, IN); end
        checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL raw_pop_cycle got=%0b exp=1", STALL); end
        cyc(); MEM_VALID = 0; #1;
        checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL raw_after got=%0b exp=0", STALL); end
        checks++; if (rf[7] !== 32'h12345678) begin failures++; $display("FAIL raw_rf7 got=%h exp=12345678", rf[7]); end
        idle();
    endtask

    task automatic test_collision();
        cyc(); LD_ISSUE = 1; LD_ADDR = 3;
        cyc(); idle(); MEM_VALID = 1; MEM_DATA = 32'hA; ALU_VALID = 1; ALU_ADDR = 4; ALU_DATA = 32'hB; #1;
        checks++; if (WRITE !== 1'b1 || INADDRESS !== 5'd3 || IN !== 32'hA) begin failures++; $display("FAIL col_mem got=%0b/%0d/%h exp=1/3/a", WRITE, INADDRESS, IN); end
        checks++; if (ALU_READY !== 1'b1) begin failures++; $display("FAIL col_ready0 got=%0b exp=1", ALU_READY); end
        cyc(); idle(); RS1_ADDR = 4; #1;
        checks++; if (ALU_READY !== 1'b0) begin failures++; $display("FAIL col_ready1 got=%0b exp=0", ALU_READY); end
        checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL col_hold_raw got=%0b exp=1", STALL); end
        checks++; if (WRITE !== 1'b1 || INADDRESS !== 5'd4 || IN !== 32'hB) begin failures++; $display("FAIL col_drain got=%0b/%0d/%h exp=1/4/b", WRITE, INADDRESS, IN); end
        cyc(); idle(); #1;
        checks++; if (ALU_READY !== 1'b1 || WRITE !== 1'b0 || STALL !== 1'b0) begin failures++; $display("FAIL col_after got=%0b%0b%0b exp=100", ALU_READY, WRITE, STALL); end
        checks++; if (rf[3] !== 32'hA || rf[4] !== 32'hB) begin failures++; $display("FAIL col_rf got=%h/%h exp=a/b", rf[3], rf[4]); end
    endtask

    task automatic test_back_to_back();
        cyc(); LD_ISSUE = 1; LD_ADDR = 10;
        cyc(); LD_ADDR = 11;
        cyc(); idle(); MEM_VALID = 1; MEM_DATA = 32'h10; ALU_VALID = 1; ALU_ADDR = 12; ALU_DATA = 32'h12; #1;
        checks++; if (INADDRESS !== 5'd10 || IN !== 32'h10) begin failures++; $display("FAIL b2b_mem0 got=%0d/%h exp=10/10", INADDRESS, IN); end
        cyc(); MEM_DATA = 32'h11; ALU_ADDR = 13; ALU_DATA = 32'h13; #1;
        checks++; if (ALU_READY !== 1'b0 || INADDRESS !== 5'd11 || IN !== 32'h11) begin failures++; $display("FAIL b2b_mem1 got=%0b/%0d/%h exp=0/11/11", ALU_READY, INADDRESS, IN); end
        cyc(); MEM_VALID = 0; #1;
        checks++; if (ALU_READY !== 1'b0 || INADDRESS !== 5'd12 || IN !== 32'h12) begin failures++; $display("FAIL b2b_hold got=%0b/%0d/%h exp=0/12/12", ALU_READY, INADDRESS, IN); end
        cyc(); #1;
        checks++; if (ALU_READY !== 1'b1 || INADDRESS !== 5'd13 || IN !== 32'h13) begin failures++; $display("FAIL b2b_alu got=%0b/%0d/%h exp=1/13/13", ALU_READY, INADDRESS, IN); end
        cyc(); idle(); #1;
        checks++; if (rf[10] !== 32'h10 || rf[11] !== 32'h11 || rf[12] !== 32'h12 || rf[13] !== 32'h13) begin failures++; $display("FAIL b2b_rf got=%h/%h/%h/%h exp=10/11/12/13", rf[10], rf[11], rf[12], rf[13]); end
    endtask

    task automatic test_full();
        logic [4:0]  addrs [4] = '{5'd2, 5'd3, 5'd2, 5'd9};
        logic        stall_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            cyc(); LD_ISSUE = 1; LD_ADDR = addrs[k];
        end
        cyc(); LD_ADDR = 20; #1;
        checks++; if (LD_READY !== 1'b0 || STALL !== 1'b1) begin failures++; $display("FAIL full_flags got=%0b%0b exp=01", LD_READY, STALL); end
        for (int k = 0; k < 4; k++) begin
            cyc(); idle(); RD_ADDR = 2; MEM_VALID = 1; MEM_DATA = 32'h100 + k; #1;
            checks++; if (INADDRESS !== addrs[k] || IN !== 32'h100 + k) begin failures++; $display("FAIL full_ret%0d got=%0d/%h exp=%0d/%h", k, INADDRESS, IN, addrs[k], 32'h100 + k); end
            checks++; if (STALL !== stall_exp[k]) begin failures++; $display("FAIL full_waw%0d got=%0b exp=%0b", k, STALL, stall_exp[k]); end
        end
        cyc(); idle(); RD_ADDR = 20; RS1_ADDR = 20; #1;
        checks++; if (STALL !== 1'b0 || LD_READY !== 1'b1 || WRITE !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b%0b%0b exp=010", STALL, LD_READY, WRITE); end
        checks++; if (rf[2] !== 32'h102 || rf[9] !== 32'h103 || ERR !== 1'b0) begin failures++; $display("FAIL full_rf got=%h/%h/%0b exp=102/103/0", rf[2], rf[9], ERR); end
        idle();
    endtask

    task automatic test_x0();
        cyc(); ALU_VALID = 1; ALU_ADDR = 0; ALU_DATA = 32'hFFFFFFFF; LD_ISSUE = 1; LD_ADDR = 0; #1;
        checks++; if (WRITE !== 1'b0 || INADDRESS !== 5'd0 || IN !== 32'd0) begin failures++; $display("FAIL x0_alu got=%0b/%0d/%h exp=0/0/0", WRITE, INADDRESS, IN); end
        cyc(); idle(); #1;
        checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0b exp=0", STALL); end
        cyc(); MEM_VALID = 1; MEM_DATA = 32'h55; #1;
        checks++; if (WRITE !== 1'b0 || IN !== 32'd0) begin failures++; $display("FAIL x0_mem got=%0b/%h exp=0/0", WRITE, IN); end
        cyc(); idle(); #1;
        checks++; if (dut.r_count !== 3'd0 || ERR !== 1'b0) begin failures++; $display("FAIL x0_count got=%0d/%0b exp=0/0", dut.r_count, ERR); end
    endtask

    task automatic test_err_reset();
        cyc(); MEM_VALID = 1; MEM_DATA = 32'h77; #1;
        checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL err_write got=%0b exp=0", WRITE); end
        cyc(); idle(); #1;
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", ERR); end
        cyc(); LD_ISSUE = 1; LD_ADDR = 5;
        cyc(); LD_ADDR = 6;
        cyc(); idle(); RS1_ADDR = 5; #1;
        checks++; if (ERR !== 1'b1 || STALL !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b%0b exp=11", ERR, STALL); end
        ALU_VALID = 1; ALU_ADDR = 8; ALU_DATA = 32'h88; RESET = 1; #1;
        checks++; if (STALL !== 1'b0 || LD_READY !== 1'b1 || ALU_READY !== 1'b1) begin failures++; $display("FAIL rst_mid got=%0b%0b%0b exp=011", STALL, LD_READY, ALU_READY); end
        checks++; if (ERR !== 1'b0 || WRITE !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%0b%0b exp=00", ERR, WRITE); end
        cyc(); RESET = 0; idle(); RS1_ADDR = 5; RD_ADDR = 6; #1;
        checks++; if (STALL !== 1'b0 || dut.r_count !== 3'd0) begin failures++; $display("FAIL rst_drop got=%0b/%0d exp=0/0", STALL, dut.r_count); end
        cyc(); idle(); MEM_VALID = 1; MEM_DATA = 32'h99; #1;
        checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL late_ret_write got=%0b exp=0", WRITE); end
        cyc(); idle(); #1;
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL late_ret_err got=%0b exp=1", ERR); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_raw();
        test_collision();
        test_back_to_back();
        test_full();
        test_x0();
        test_err_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
